term_writer: RTL and testbench
==============================

TERM_WRITER -- requirements
Module: term_writer

Interface
REQ-001 SHALL have parameter COLS, default 106, meaning character columns per row (640 px / 6 px cell).
REQ-002 SHALL have parameter ROWS, default 36, meaning character rows per screen (404 lines / 11 line cell).
REQ-003 SHALL have port i_clk  input  1  meaning the single clock; all logic on posedge.
REQ-004 SHALL have port i_reset  input  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have port i_data  input  8  meaning incoming character byte.
REQ-006 SHALL have port i_valid  input  1  meaning i_data is valid.
REQ-007 SHALL have port o_ready  output  1  meaning the block accepts i_data this cycle.
REQ-008 SHALL have port o_we  output  1  meaning video RAM write strobe, one write per cycle.
REQ-009 SHALL have port o_waddr  output  12  meaning video RAM cell address, row*COLS+col.
REQ-010 SHALL have port o_wdata  output  8  meaning character code written to the video RAM.
REQ-011 SHALL have port o_busy  output  1  meaning a clear-screen or clear-line sweep is in progress.

Function
REQ-012 SHALL use FSM states CLEAR, IDLE, WRITE, CLRLINE.
REQ-013 SHALL transfer a byte on a posedge where i_valid && o_ready; o_ready SHALL be high only in IDLE.
REQ-014 Printable byte (0x20..0x7E): SHALL enter WRITE; o_we=1, o_waddr=cursor, o_wdata=byte for exactly one cycle (latency 1); then col+1.
REQ-015 After a write at col COLS-1, SHALL set col=0 and advance the row (REQ-019).
REQ-016 0x0D (CR): SHALL set col=0; no write; SHALL return to IDLE after 1 cycle.
REQ-017 0x0A (LF): SHALL set col=0 and advance the row.
REQ-018 0x0C (FF): SHALL enter CLEAR and home the cursor.
REQ-019 Row advance: row+1, wrapping ROWS-1 to 0; SHALL then enter CLRLINE to write 0x20 to all COLS cells of the new row, in ascending address order, one per cycle, o_busy=1, then return to IDLE.
REQ-020 CLEAR SHALL write 0x20 to addresses 0..ROWS*COLS-1, one per cycle, ascending, o_busy=1, then set cursor (0,0) and enter IDLE.
REQ-021 All other bytes (<0x20 not listed above, and 0x7F..0xFF) SHALL be accepted and ignored, with no write and no cursor change.
REQ-022 The cell address SHALL be kept as a running 12-bit counter, with no multiplier; ROWS*COLS SHALL be <= 4096 (elaboration error otherwise).
REQ-023 When not writing, o_we SHALL be 0 and o_waddr/o_wdata SHALL hold their last values.

Reset
REQ-024 i_reset SHALL force: cursor (0,0), address 0, o_we=0, o_wdata=0x20, o_ready=0, o_busy=1, state CLEAR.
REQ-025 Reset asserted mid-sweep or mid-write SHALL abort that operation and restart the full clear from address 0 on the cycle after release.

Configuration
REQ-026 Macro TERM_BACKSPACE_EN defined: 0x08 with col>0 SHALL set col-1 and write 0x20 at the new cursor (one WRITE cycle); with col=0 it SHALL have no effect.
REQ-027 Macro TERM_BACKSPACE_EN undefined: 0x08 SHALL be ignored per REQ-021.

Structure
REQ-028 Package term_pkg SHALL hold the default COLS/ROWS, the FSM state encoding, and the constants CH_CR=0x0D, CH_LF=0x0A, CH_FF=0x0C, CH_BS=0x08, CH_SPACE=0x20.
REQ-029 Sub-module term_cursor SHALL hold the col/row/address counters, with inc, home, newline, back, and wrap outputs; the FSM stays in term_writer.

Verification
REQ-030 Reset, then no input: exactly 3816 o_we pulses with o_wdata=0x20 at addr 0..3815; then o_ready=1 and o_busy=0.
REQ-031 Send "AB": writes 0x41@0 then 0x42@1; each o_we occurs 1 cycle after acceptance; o_ready is low during each write cycle.
REQ-032 Send 106 x 'x': the last write is @105; then 106 clears 0x20@106..211; cursor then at (0,1), next char written @106.
REQ-033 Cursor at row 35, send 0x0A: clear sweep at 0..105 (row 0 wrap); next char written @0.
REQ-034 With TERM_BACKSPACE_EN: "A",0x08 gives 0x41@0 then 0x20@0; a second 0x08 gives no write. Without it: 0x08 gives no write and the cursor stays at 1.
REQ-035 Assert i_reset at clear address 50 of a sweep: after release, the sweep restarts at 0 and completes 3816 writes.

Source files
------------

// File: rtl/term_pkg.sv
// Shared definitions for the character-terminal writer: default geometry,
// FSM encoding and the control characters it interprets.
package term_pkg;

    localparam int COLS_DEF = 106;
    localparam int ROWS_DEF = 36;

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        IDLE    = 2'd1,
        WRITE   = 2'd2,
        CLRLINE = 2'd3
    } term_state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    function automatic logic is_sweep(input term_state_t s);
        return (s == CLEAR) || (s == CLRLINE);
    endfunction

endpackage

// File: rtl/term_cursor.sv
// Cursor column/row/cell-address counters for term_writer; the address is a
// running counter plus a row base so no multiplier is needed.
// Optional macro: TERM_BACKSPACE_EN adds the o_col_zero output.
module term_cursor
    import term_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_inc,
    input  logic        i_home,
    input  logic        i_newline,
    input  logic        i_cr,
    input  logic        i_back,
    output logic [11:0] o_addr,
    output logic        o_wrap,
`ifdef TERM_BACKSPACE_EN
    output logic        o_col_zero,
`endif
    output logic        o_last_cell
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;
    logic [11:0]   addr_r;
    logic [11:0]   base_r;
    logic          wrap_s;
    logic          last_row_s;
    logic [11:0]   next_base_s;

    assign wrap_s      = (col_r == CW'(COLS - 1));
    assign last_row_s  = (row_r == RW'(ROWS - 1));
    assign next_base_s = last_row_s ? 12'd0 : (base_r + 12'(COLS));

    // Cursor update; an inc past the last column behaves like a newline
    always_ff @(posedge i_clk) begin
        if (i_reset || i_home) begin
            col_r  <= {CW{1'b0}};
            row_r  <= {RW{1'b0}};
            addr_r <= 12'd0;
            base_r <= 12'd0;
        end else if (i_newline || (i_inc && wrap_s)) begin
            col_r  <= {CW{1'b0}};
            row_r  <= last_row_s ? {RW{1'b0}} : (row_r + RW'(1'b1));
            addr_r <= next_base_s;
            base_r <= next_base_s;
        end else if (i_cr) begin
            col_r  <= {CW{1'b0}};
            addr_r <= base_r;
        end else if (i_back) begin
            col_r  <= col_r - CW'(1'b1);
            addr_r <= addr_r - 12'd1;
        end else if (i_inc) begin
            col_r  <= col_r + CW'(1'b1);
            addr_r <= addr_r + 12'd1;
        end
    end

    assign o_addr      = addr_r;
    assign o_wrap      = wrap_s;
    assign o_last_cell = wrap_s && last_row_s;
`ifdef TERM_BACKSPACE_EN
    assign o_col_zero  = (col_r == {CW{1'b0}});
`endif

endmodule

// File: rtl/term_writer.sv
// Character-stream to video-RAM writer: places printable bytes at the cursor,
// handles CR/LF/FF, and sweeps spaces for screen and line clears.
// Optional macro: TERM_BACKSPACE_EN enables 0x08 as erase-previous-cell.
module term_writer
    import term_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_we,
    output logic [11:0] o_waddr,
    output logic [7:0]  o_wdata,
    output logic        o_busy
);

    generate
        if (ROWS * COLS > 4096) begin : g_size_check
            $error("term_writer: ROWS*COLS does not fit a 12-bit cell address");
        end
    endgenerate

    term_state_t state_r, state_next_s;
    logic        we_r, we_next_s;
    logic [11:0] waddr_r, waddr_next_s;
    logic [7:0]  wdata_r, wdata_next_s;
    logic        ready_r, ready_next_s;
    logic        busy_r, busy_next_s;
    logic        wr_back_r, wr_back_next_s;
    logic        accept_s;
    logic        cur_inc_s, cur_home_s, cur_newline_s, cur_cr_s, cur_back_s;
    logic [11:0] cur_addr_s;
    logic        cur_wrap_s, cur_last_cell_s;
`ifdef TERM_BACKSPACE_EN
    logic        cur_col_zero_s;
`endif

    term_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_inc       (cur_inc_s),
        .i_home      (cur_home_s),
        .i_newline   (cur_newline_s),
        .i_cr        (cur_cr_s),
        .i_back      (cur_back_s),
        .o_addr      (cur_addr_s),
        .o_wrap      (cur_wrap_s),
`ifdef TERM_BACKSPACE_EN
        .o_col_zero  (cur_col_zero_s),
`endif
        .o_last_cell (cur_last_cell_s)
    );

    assign accept_s = i_valid && ready_r;

    // Next-state, next-output and cursor-command decode
    always_comb begin
        state_next_s   = state_r;
        we_next_s      = 1'b0;
        waddr_next_s   = waddr_r;
        wdata_next_s   = wdata_r;
        wr_back_next_s = wr_back_r;
        cur_inc_s      = 1'b0;
        cur_home_s     = 1'b0;
        cur_newline_s  = 1'b0;
        cur_cr_s       = 1'b0;
        cur_back_s     = 1'b0;
        case (state_r)
            CLEAR: begin
                we_next_s    = 1'b1;
                waddr_next_s = cur_addr_s;
                wdata_next_s = CH_SPACE;
                if (cur_last_cell_s) begin
                    cur_home_s   = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    cur_inc_s = 1'b1;
                end
            end
            IDLE: begin
                if (!accept_s) begin
                    state_next_s = IDLE;
                end else if (is_printable(i_data)) begin
                    we_next_s      = 1'b1;
                    waddr_next_s   = cur_addr_s;
                    wdata_next_s   = i_data;
                    wr_back_next_s = 1'b0;
                    state_next_s   = WRITE;
                end else if (i_data == CH_CR) begin
                    cur_cr_s = 1'b1;
                end else if (i_data == CH_LF) begin
                    cur_newline_s = 1'b1;
                    state_next_s  = CLRLINE;
                end else if (i_data == CH_FF) begin
                    cur_home_s   = 1'b1;
                    state_next_s = CLEAR;
`ifdef TERM_BACKSPACE_EN
                end else if ((i_data == CH_BS) && !cur_col_zero_s) begin
                    we_next_s      = 1'b1;
                    waddr_next_s   = cur_addr_s - 12'd1;
                    wdata_next_s   = CH_SPACE;
                    wr_back_next_s = 1'b1;
                    state_next_s   = WRITE;
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITE: begin
                // The write itself is already on the outputs; only the cursor moves here
                if (wr_back_r) begin
                    cur_back_s   = 1'b1;
                    state_next_s = IDLE;
                end else if (cur_wrap_s) begin
                    cur_newline_s = 1'b1;
                    state_next_s  = CLRLINE;
                end else begin
                    cur_inc_s    = 1'b1;
                    state_next_s = IDLE;
                end
            end
            CLRLINE: begin
                we_next_s    = 1'b1;
                waddr_next_s = cur_addr_s;
                wdata_next_s = CH_SPACE;
                if (cur_wrap_s) begin
                    cur_cr_s     = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    cur_inc_s = 1'b1;
                end
            end
            default: begin
                cur_home_s   = 1'b1;
                state_next_s = CLEAR;
            end
        endcase
        ready_next_s = (state_next_s == IDLE) && !we_next_s;
        busy_next_s  = is_sweep(state_next_s) || is_sweep(state_r);
    end

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r   <= CLEAR;
            we_r      <= 1'b0;
            waddr_r   <= 12'd0;
            wdata_r   <= CH_SPACE;
            ready_r   <= 1'b0;
            busy_r    <= 1'b1;
            wr_back_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            we_r      <= we_next_s;
            waddr_r   <= waddr_next_s;
            wdata_r   <= wdata_next_s;
            ready_r   <= ready_next_s;
            busy_r    <= busy_next_s;
            wr_back_r <= wr_back_next_s;
        end
    end

    assign o_ready = ready_r;
    assign o_we    = we_r;
    assign o_waddr = waddr_r;
    assign o_wdata = wdata_r;
    assign o_busy  = busy_r;

endmodule

// File: tb/tb_term_writer.sv
// Bench for term_writer: a screen-level model predicts the ordered stream of
// RAM writes; directed byte sequences plus literal checks pin key cases.
module tb_term_writer;

    localparam int COLS  = 106;
    localparam int ROWS  = 36;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        o_ready;
    logic        o_we;
    logic [11:0] o_waddr;
    logic [7:0]  o_wdata;
    logic        o_busy;

    always #5 clk = ~clk;

    term_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_we    (o_we),
        .o_waddr (o_waddr),
        .o_wdata (o_wdata),
        .o_busy  (o_busy)
    );

    typedef struct {
        int addr;
        int data;
        int sweep;
    } wr_t;

    wr_t exp_q[$];
    int  mcol = 0;
    int  mrow = 0;
    bit  pend_clear = 1'b0;
    bit  accepted = 1'b0;
    int  vectors = 0;
    int  miscompares = 0;
    int  total_writes = 0;
    int  last_addr = -1;
    int  last_data = -1;
    int  mark = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push_w(input int a, input int d, input int s);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.sweep = s;
        exp_q.push_back(e);
    endfunction

    function automatic void new_row();
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
        for (int c = 0; c < COLS; c++) push_w(mrow * COLS + c, 32'h20, 1);
    endfunction

    function automatic void clear_screen();
        for (int a = 0; a < CELLS; a++) push_w(a, 32'h20, 1);
        mrow = 0;
        mcol = 0;
    endfunction

    // Screen-level meaning of one accepted byte
    function automatic void model_byte(input int b);
        if (b >= 32'h20 && b <= 32'h7E) begin
            push_w(mrow * COLS + mcol, b, 0);
            mcol++;
            if (mcol == COLS) new_row();
        end else if (b == 32'h0D) begin
            mcol = 0;
        end else if (b == 32'h0A) begin
            new_row();
        end else if (b == 32'h0C) begin
            clear_screen();
`ifdef TERM_BACKSPACE_EN
        end else if (b == 32'h08 && mcol > 0) begin
            mcol--;
            push_w(mrow * COLS + mcol, 32'h20, 0);
`endif
        end
    endfunction

    // One clock: compare any write against the model at negedge, then update
    // the model with what the coming posedge will accept.
    task automatic step();
        wr_t e;
        @(negedge clk);
        accepted = 1'b0;
        if (o_we === 1'b1) begin
            total_writes++;
            last_addr = int'(o_waddr);
            last_data = int'(o_wdata);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", int'(o_waddr), -1);
            end else begin
                e = exp_q.pop_front();
                chk("waddr", int'(o_waddr), e.addr);
                chk("wdata", int'(o_wdata), e.data);
                chk("busy_on_write", int'(o_busy), e.sweep);
                chk("ready_on_write", int'(o_ready), 0);
            end
        end
        if (rst) begin
            exp_q.delete();
            mcol = 0;
            mrow = 0;
            pend_clear = 1'b1;
        end else if (pend_clear) begin
            clear_screen();
            pend_clear = 1'b0;
        end else if (i_valid && o_ready) begin
            model_byte(int'(i_data));
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bit done = 1'b0;
        i_valid = 1'b1;
        i_data  = b;
        for (int i = 0; i < 10000 && !done; i++) begin
            step();
            done = accepted;
        end
        i_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            if (exp_q.size() == 0 && o_ready === 1'b1 && o_we === 1'b0) done = 1'b1;
            else step();
        end
        if (!done) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        bit hit;
        rst = 1'b1;
        i_valid = 1'b0;
        i_data = 8'h00;
        repeat (3) step();
        chk("rst_we", int'(o_we), 0);
        chk("rst_waddr", int'(o_waddr), 0);
        chk("rst_wdata", int'(o_wdata), 32'h20);
        chk("rst_ready", int'(o_ready), 0);
        chk("rst_busy", int'(o_busy), 1);

        rst = 1'b0;
        mark = total_writes;
        wait_idle();
        chk("init_clear_count", total_writes - mark, 3816);
        chk("init_clear_last", last_addr, 3815);
        chk("idle_busy", int'(o_busy), 0);
        chk("idle_ready", int'(o_ready), 1);

        send(8'h41);
        chk("A_we", int'(o_we), 1);
        chk("A_addr", int'(o_waddr), 0);
        chk("A_data", int'(o_wdata), 32'h41);
        chk("A_ready", int'(o_ready), 0);
        step();
        chk("A_single_pulse", int'(o_we), 0);
        send(8'h42);
        chk("B_addr", int'(o_waddr), 1);
        chk("B_data", int'(o_wdata), 32'h42);
        chk("B_ready", int'(o_ready), 0);
        wait_idle();

        mark = total_writes;
        send(8'h0D);
        wait_idle();
        chk("cr_no_write", total_writes - mark, 0);

        mark = total_writes;
        for (int i = 0; i < COLS; i++) send(8'h78);
        chk("row_last_addr", int'(o_waddr), 105);
        wait_idle();
        chk("row_fill_writes", total_writes - mark, 212);
        chk("row1_clear_last", last_addr, 211);
        chk("row1_clear_data", last_data, 32'h20);
        send(8'h51);
        chk("row1_first", int'(o_waddr), 106);
        send(8'h20);
        chk("space_addr", int'(o_waddr), 107);
        send(8'h7E);
        chk("tilde_data", int'(o_wdata), 32'h7E);
        send(8'h1F);
        send(8'h7F);
        send(8'hFF);
        send(8'h44);
        chk("after_ignored", int'(o_waddr), 109);
        wait_idle();

        for (int i = 0; i < 34; i++) send(8'h0A);
        wait_idle();
        mark = total_writes;
        send(8'h0A);
        wait_idle();
        chk("wrap_clear_count", total_writes - mark, 106);
        chk("wrap_clear_last", last_addr, 105);
        send(8'h5A);
        chk("wrap_next_char", int'(o_waddr), 0);
        wait_idle();

        send(8'h0C);
        wait_idle();
        send(8'h41);
        wait_idle();
        mark = total_writes;
        send(8'h08);
        wait_idle();
`ifdef TERM_BACKSPACE_EN
        chk("bs_one_write", total_writes - mark, 1);
        chk("bs_addr", last_addr, 0);
        chk("bs_data", last_data, 32'h20);
        mark = total_writes;
        send(8'h08);
        wait_idle();
        chk("bs_col0_none", total_writes - mark, 0);
        send(8'h43);
        chk("bs_next_char", int'(o_waddr), 0);
`else
        chk("bs_ignored", total_writes - mark, 0);
        send(8'h43);
        chk("bs_next_char", int'(o_waddr), 1);
`endif
        wait_idle();

        send(8'h0C);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            step();
            if (o_we === 1'b1 && o_waddr == 12'd50) hit = 1'b1;
        end
        chk("reach_addr50", int'(hit), 1);
        rst = 1'b1;
        step();
        step();
        chk("midrst_we", int'(o_we), 0);
        chk("midrst_busy", int'(o_busy), 1);
        chk("midrst_waddr", int'(o_waddr), 0);
        rst = 1'b0;
        mark = total_writes;
        wait_idle();
        chk("midrst_count", total_writes - mark, 3816);
        chk("midrst_last", last_addr, 3815);

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
